// File: rtl/ahbmtx_l2_addr_decoder_pkg.sv
// Shared AHB matrix definitions: response encodings and data-phase select state.
package ahbmtx_l2_addr_decoder_pkg;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam int unsigned NUM_SLAVES = 4;

    // Which responder owns the current data phase.
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_S0   = 3'd1,
        SEL_S1   = 3'd2,
        SEL_S2   = 3'd3,
        SEL_S3   = 3'd4,
        SEL_DEF  = 3'd5
    } dsel_e;

endpackage

// File: rtl/ahbmtx_l2_region_match.sv
// Single address-region comparator: hit when the masked address equals the base.
module ahbmtx_l2_region_match #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter logic [31:0] MASK = 32'hE000_0000
) (
    input  logic [31:0] addr_i,
    output logic        hit_o
);

    assign hit_o = ((addr_i & MASK) == BASE);

endmodule

// File: rtl/ahbmtx_l2_addr_decoder.sv
// Output-stage address decoder of the AHB matrix: four slave regions plus a
// default slave, a data-phase response mux and a saturating default-hit counter.
module ahbmtx_l2_addr_decoder
    import ahbmtx_l2_addr_decoder_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hE000_0000,
    parameter logic [31:0] S1_BASE = 32'h2000_0000,
    parameter logic [31:0] S1_MASK = 32'hE000_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000,
    parameter logic [31:0] S3_BASE = 32'h6000_0000,
    parameter logic [31:0] S3_MASK = 32'hF000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSELS,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    output logic [3:0]  HSEL_S,
    output logic        HSEL_DEF,
    input  logic [3:0]  HREADYOUT_S,
    input  logic [1:0]  HRESP_S0,
    input  logic [1:0]  HRESP_S1,
    input  logic [1:0]  HRESP_S2,
    input  logic [1:0]  HRESP_S3,
    input  logic [31:0] HRDATA_S0,
    input  logic [31:0] HRDATA_S1,
    input  logic [31:0] HRDATA_S2,
    input  logic [31:0] HRDATA_S3,
    input  logic        HREADYOUT_DEF,
    input  logic [1:0]  HRESP_DEF,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    input  logic        DEF_CNT_CLR,
    output logic [15:0] DEF_HIT_CNT
);

    logic [3:0]  hit;
    logic [3:0]  win;
    dsel_e       addr_sel;
    dsel_e       sel_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        def_hit;
    logic        unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    ahbmtx_l2_region_match #(.BASE(S0_BASE), .MASK(S0_MASK)) u_match0 (.addr_i(HADDR), .hit_o(hit[0]));
    ahbmtx_l2_region_match #(.BASE(S1_BASE), .MASK(S1_MASK)) u_match1 (.addr_i(HADDR), .hit_o(hit[1]));
    ahbmtx_l2_region_match #(.BASE(S2_BASE), .MASK(S2_MASK)) u_match2 (.addr_i(HADDR), .hit_o(hit[2]));
    ahbmtx_l2_region_match #(.BASE(S3_BASE), .MASK(S3_MASK)) u_match3 (.addr_i(HADDR), .hit_o(hit[3]));

    // Address-phase decode: lowest-index region wins on overlap, default when none hit.
    always_comb begin
        win      = '0;
        addr_sel = SEL_DEF;
        if (hit[0]) begin
            win[0]   = 1'b1;
            addr_sel = SEL_S0;
        end else if (hit[1]) begin
            win[1]   = 1'b1;
            addr_sel = SEL_S1;
        end else if (hit[2]) begin
            win[2]   = 1'b1;
            addr_sel = SEL_S2;
        end else if (hit[3]) begin
            win[3]   = 1'b1;
            addr_sel = SEL_S3;
        end
        if (!HSELS) begin
            addr_sel = SEL_NONE;
        end
    end

    assign HSEL_S   = win & {4{HSELS}};
    assign HSEL_DEF = HSELS & ~(|hit);
    assign def_hit  = HSEL_DEF & HREADY & HTRANS[1];

    // Data-phase owner advances only when the bus completes the current transfer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= SEL_NONE;
        end else if (HREADY) begin
            sel_q <= addr_sel;
        end
    end

    // Saturating counter next state; clear beats a coincident hit.
    always_comb begin
        cnt_d = cnt_q;
        if (DEF_CNT_CLR) begin
            cnt_d = '0;
        end else if (def_hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Default-slave hit counter register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign DEF_HIT_CNT = cnt_q;

    // Response mux driven by the registered data-phase owner.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        case (sel_q)
            SEL_S0: begin
                HREADYOUT = HREADYOUT_S[0];
                HRESP     = HRESP_S0;
                HRDATA    = HRDATA_S0;
            end
            SEL_S1: begin
                HREADYOUT = HREADYOUT_S[1];
                HRESP     = HRESP_S1;
                HRDATA    = HRDATA_S1;
            end
            SEL_S2: begin
                HREADYOUT = HREADYOUT_S[2];
                HRESP     = HRESP_S2;
                HRDATA    = HRDATA_S2;
            end
            SEL_S3: begin
                HREADYOUT = HREADYOUT_S[3];
                HRESP     = HRESP_S3;
                HRDATA    = HRDATA_S3;
            end
            SEL_DEF: begin
                HREADYOUT = HREADYOUT_DEF;
                HRESP     = HRESP_DEF;
            end
            default: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_OKAY;
                HRDATA    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ahbmtx_l2_addr_decoder.sv
// Bench for the matrix output-stage decoder. Region 3 is overridden to overlap
// region 2 so that lowest-index priority is exercised (0x4xxxxxxx -> S2, 0x5xxxxxxx -> S3).
module tb_ahbmtx_l2_addr_decoder;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [3:0]  HSEL_S;
    logic        HSEL_DEF;
    logic [3:0]  HREADYOUT_S;
    logic [1:0]  HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3;
    logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
    logic        HREADYOUT_DEF;
    logic [1:0]  HRESP_DEF;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic        DEF_CNT_CLR;
    logic [15:0] DEF_HIT_CNT;

    logic [31:0] s_rdata [4];
    logic [1:0]  s_resp  [4];

    assign HRDATA_S0 = s_rdata[0];
    assign HRDATA_S1 = s_rdata[1];
    assign HRDATA_S2 = s_rdata[2];
    assign HRDATA_S3 = s_rdata[3];
    assign HRESP_S0  = s_resp[0];
    assign HRESP_S1  = s_resp[1];
    assign HRESP_S2  = s_resp[2];
    assign HRESP_S3  = s_resp[3];

    always #5 HCLK = ~HCLK;

    ahbmtx_l2_addr_decoder #(
        .S3_BASE(32'h4000_0000),
        .S3_MASK(32'hC000_0000)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDR(HADDR),
        .HTRANS(HTRANS), .HREADY(HREADY), .HSEL_S(HSEL_S), .HSEL_DEF(HSEL_DEF),
        .HREADYOUT_S(HREADYOUT_S),
        .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2), .HRESP_S3(HRESP_S3),
        .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1), .HRDATA_S2(HRDATA_S2), .HRDATA_S3(HRDATA_S3),
        .HREADYOUT_DEF(HREADYOUT_DEF), .HRESP_DEF(HRESP_DEF),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .DEF_CNT_CLR(DEF_CNT_CLR), .DEF_HIT_CNT(DEF_HIT_CNT)
    );

    localparam logic [31:0] RB [4] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h4000_0000};
    localparam logic [31:0] RM [4] = '{32'hE000_0000, 32'hE000_0000, 32'hF000_0000, 32'hC000_0000};

    int checks   = 0;
    int failures = 0;
    int m_sel    = -1;   // -1 none, 0..3 slave, 4 default
    int m_cnt    = 0;

    // Region lookup in priority order; 4 means the default slave.
    function automatic int ref_region(logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & RM[i]) == RB[i]) return i;
        end
        return 4;
    endfunction

    function automatic logic [3:0] exp_hsel();
        int r;
        r = ref_region(HADDR);
        if (!HSELS || r == 4) return 4'b0000;
        return 4'(1) << r;
    endfunction

    function automatic logic exp_hsel_def();
        return HSELS && (ref_region(HADDR) == 4);
    endfunction

    function automatic logic exp_ready();
        if (m_sel < 0) return 1'b1;
        if (m_sel == 4) return HREADYOUT_DEF;
        return HREADYOUT_S[m_sel];
    endfunction

    function automatic logic [1:0] exp_resp();
        if (m_sel < 0) return 2'b00;
        if (m_sel == 4) return HRESP_DEF;
        return s_resp[m_sel];
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (m_sel < 0 || m_sel == 4) return 32'h0;
        return s_rdata[m_sel];
    endfunction

    // Advance one clock, updating the reference model from the inputs sampled at the edge.
    task automatic tick();
        int nsel;
        int ncnt;
        nsel = m_sel;
        ncnt = m_cnt;
        if (HRESET) begin
            nsel = -1;
            ncnt = 0;
        end else begin
            if (HREADY) nsel = HSELS ? ref_region(HADDR) : -1;
            if (DEF_CNT_CLR) ncnt = 0;
            else if (HSELS && ref_region(HADDR) == 4 && HREADY && HTRANS[1] && m_cnt < 65535)
                ncnt = m_cnt + 1;
        end
        @(posedge HCLK);
        m_sel = nsel;
        m_cnt = ncnt;
        #1;
        for (int i = 0; i < 4; i++) s_rdata[i] = $urandom;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick();
        tick();
        checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL reset_hreadyout got=%b exp=1", HREADYOUT); end
        checks++; if (HRESP !== 2'b00) begin failures++; $display("FAIL reset_hresp got=%b exp=00", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", HRDATA); end
        checks++; if (DEF_HIT_CNT !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", DEF_HIT_CNT); end
        HRESET = 1'b0;
    endtask

    task automatic test_slave1_read();
        HSELS = 1'b1; HADDR = 32'h2000_0010; HTRANS = 2'b10; HREADY = 1'b1;
        #1;
        checks++; if (HSEL_S !== 4'b0010) begin failures++; $display("FAIL s1_hsel got=%b exp=0010", HSEL_S); end
        checks++; if (HSEL_DEF !== 1'b0) begin failures++; $display("FAIL s1_hsel_def got=%b exp=0", HSEL_DEF); end
        tick();
        HSELS = 1'b0; HTRANS = 2'b00;
        #1;
        checks++; if (HRDATA !== s_rdata[1]) begin failures++; $display("FAIL s1_rdata got=%h exp=%h", HRDATA, s_rdata[1]); end
        checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL s1_ready got=%b exp=1", HREADYOUT); end
        tick();
    endtask

    task automatic test_default_error();
        HSELS = 1'b0; DEF_CNT_CLR = 1'b1;
        tick();
        DEF_CNT_CLR = 1'b0;
        HSELS = 1'b1; HADDR = 32'h8000_0000; HTRANS = 2'b10; HREADY = 1'b1;
        HREADYOUT_DEF = 1'b0; HRESP_DEF = 2'b01;
        #1;
        checks++; if (HSEL_DEF !== 1'b1) begin failures++; $display("FAIL def_hsel_def got=%b exp=1", HSEL_DEF); end
        checks++; if (HSEL_S !== 4'b0000) begin failures++; $display("FAIL def_hsel got=%b exp=0000", HSEL_S); end
        tick();
        HSELS = 1'b0; HTRANS = 2'b00; HREADY = 1'b0;
        #1;
        checks++; if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL def_err1_ready got=%b exp=0", HREADYOUT); end
        checks++; if (HRESP !== 2'b01) begin failures++; $display("FAIL def_err1_resp got=%b exp=01", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL def_rdata got=%h exp=0", HRDATA); end
        checks++; if (DEF_HIT_CNT !== 16'd1) begin failures++; $display("FAIL def_cnt got=%0d exp=1", DEF_HIT_CNT); end
        tick();
        HREADYOUT_DEF = 1'b1;
        #1;
        checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL def_err2_ready got=%b exp=1", HREADYOUT); end
        checks++; if (HRESP !== 2'b01) begin failures++; $display("FAIL def_err2_resp got=%b exp=01", HRESP); end
        HREADY = 1'b1;
        tick();
        HRESP_DEF = 2'b00;
    endtask

    task automatic test_wait_hold();
        HSELS = 1'b1; HADDR = 32'h4000_0100; HTRANS = 2'b10; HREADY = 1'b1;
        tick();
        HREADYOUT_S[2] = 1'b0; HREADY = 1'b0; HADDR = 32'h0000_0200;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL wait_ready c=%0d got=%b exp=0", c, HREADYOUT); end
            checks++; if (HSEL_S !== 4'b0001) begin failures++; $display("FAIL wait_hsel c=%0d got=%b exp=0001", c, HSEL_S); end
            tick();
        end
        HREADYOUT_S[2] = 1'b1; HREADY = 1'b1;
        #1;
        checks++; if (HRDATA !== s_rdata[2]) begin failures++; $display("FAIL wait_s2_rdata got=%h exp=%h", HRDATA, s_rdata[2]); end
        tick();
        HSELS = 1'b0; HTRANS = 2'b00;
        #1;
        checks++; if (HRDATA !== s_rdata[0]) begin failures++; $display("FAIL wait_s0_rdata got=%h exp=%h", HRDATA, s_rdata[0]); end
        tick();
    endtask

    task automatic test_saturation();
        HSELS = 1'b0; DEF_CNT_CLR = 1'b1;
        tick();
        DEF_CNT_CLR = 1'b0;
        HSELS = 1'b1; HADDR = 32'h8000_0000; HTRANS = 2'b10; HREADY = 1'b1;
        HREADYOUT_DEF = 1'b1; HRESP_DEF = 2'b00;
        for (int i = 0; i < 65535; i++) tick();
        checks++; if (DEF_HIT_CNT !== 16'hFFFF) begin failures++; $display("FAIL sat_full got=%h exp=ffff", DEF_HIT_CNT); end
        tick();
        checks++; if (DEF_HIT_CNT !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", DEF_HIT_CNT); end
        DEF_CNT_CLR = 1'b1;
        tick();
        DEF_CNT_CLR = 1'b0;
        checks++; if (DEF_HIT_CNT !== 16'h0) begin failures++; $display("FAIL sat_clr got=%h exp=0", DEF_HIT_CNT); end
        HSELS = 1'b0; HTRANS = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        HSELS = 1'b1; HADDR = 32'h9000_0000; HTRANS = 2'b10; HREADY = 1'b1;
        tick();
        HADDR = 32'h6000_0040;
        tick();
        HSELS = 1'b0; HTRANS = 2'b00; HREADY = 1'b0;
        HREADYOUT_S[3] = 1'b0; s_resp[3] = 2'b01;
        #1;
        checks++; if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL rstw_pre_ready got=%b exp=0", HREADYOUT); end
        checks++; if (DEF_HIT_CNT === 16'h0) begin failures++; $display("FAIL rstw_pre_cnt got=%h exp=nonzero", DEF_HIT_CNT); end
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        #1;
        checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rstw_ready got=%b exp=1", HREADYOUT); end
        checks++; if (HRESP !== 2'b00) begin failures++; $display("FAIL rstw_resp got=%b exp=00", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL rstw_rdata got=%h exp=0", HRDATA); end
        checks++; if (DEF_HIT_CNT !== 16'h0) begin failures++; $display("FAIL rstw_cnt got=%h exp=0", DEF_HIT_CNT); end
        HREADYOUT_S[3] = 1'b1; s_resp[3] = 2'b00; HREADY = 1'b1;
        tick();
    endtask

    task automatic test_hsels_low();
        for (int i = 0; i < 20; i++) begin
            HSELS = 1'b0; HADDR = $urandom; HTRANS = 2'($urandom); HREADY = 1'b1;
            #1;
            checks++; if (HSEL_S !== 4'b0000) begin failures++; $display("FAIL low_hsel got=%b exp=0000", HSEL_S); end
            checks++; if (HSEL_DEF !== 1'b0) begin failures++; $display("FAIL low_hsel_def got=%b exp=0", HSEL_DEF); end
            tick();
            checks++; if (HREADYOUT !== 1'b1 || HRESP !== 2'b00 || HRDATA !== 32'h0) begin
                failures++;
                $display("FAIL low_none_resp got=%b/%b/%h exp=1/00/0", HREADYOUT, HRESP, HRDATA);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pick [7];
        pick = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h5000_0000,
                 32'h6000_0000, 32'h8000_0000, 32'hE000_0000};
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) HADDR = $urandom;
            else HADDR = pick[$urandom_range(0, 6)] | ($urandom & 32'h0FFF_FFFF);
            HSELS         = ($urandom_range(0, 4) != 0);
            HTRANS        = 2'($urandom);
            HREADY        = ($urandom_range(0, 4) != 0);
            DEF_CNT_CLR   = ($urandom_range(0, 19) == 0);
            HREADYOUT_S   = 4'($urandom);
            HREADYOUT_DEF = 1'($urandom);
            HRESP_DEF     = 2'($urandom);
            for (int s = 0; s < 4; s++) s_resp[s] = 2'($urandom);
            #1;
            checks++; if (HSEL_S !== exp_hsel()) begin failures++; $display("FAIL rnd_hsel i=%0d addr=%h got=%b exp=%b", i, HADDR, HSEL_S, exp_hsel()); end
            checks++; if (HSEL_DEF !== exp_hsel_def()) begin failures++; $display("FAIL rnd_hsel_def i=%0d addr=%h got=%b exp=%b", i, HADDR, HSEL_DEF, exp_hsel_def()); end
            checks++; if (HREADYOUT !== exp_ready()) begin failures++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, HREADYOUT, exp_ready()); end
            checks++; if (HRESP !== exp_resp()) begin failures++; $display("FAIL rnd_resp i=%0d got=%b exp=%b", i, HRESP, exp_resp()); end
            checks++; if (HRDATA !== exp_rdata()) begin failures++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, HRDATA, exp_rdata()); end
            checks++; if (DEF_HIT_CNT !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, DEF_HIT_CNT, m_cnt); end
            tick();
        end
        DEF_CNT_CLR = 1'b0; HREADYOUT_S = 4'hF; HREADYOUT_DEF = 1'b1; HRESP_DEF = 2'b00;
        for (int s = 0; s < 4; s++) s_resp[s] = 2'b00;
        HSELS = 1'b0; HREADY = 1'b1;
        tick();
    endtask

    initial begin
        HRESET = 1'b1; HSELS = 1'b0; HADDR = '0; HTRANS = 2'b00; HREADY = 1'b1;
        HREADYOUT_S = 4'hF; HREADYOUT_DEF = 1'b1; HRESP_DEF = 2'b00; DEF_CNT_CLR = 1'b0;
        for (int s = 0; s < 4; s++) begin
            s_rdata[s] = $urandom;
            s_resp[s]  = 2'b00;
        end
        test_reset();
        test_slave1_read();
        test_default_error();
        test_wait_hold();
        test_hsels_low();
        test_random();
        test_saturation();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
